// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the architectural PC and issues
// single-outstanding requests to instruction memory over a req/ready
// handshake. Fetched {pc, instruction} pairs go into a small FIFO whose head
// is presented, registered, at the IF/ID boundary. Decode stalls are absorbed
// by the FIFO. Redirects flush the FIFO, and a request still outstanding when
// a redirect arrives is drained and its data is dropped.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   imem_req       fetch request valid (held stable until imem_ready)
//   imem_addr      fetch address, word aligned
//   imem_ready     memory accepts request; imem_rdata valid in that cycle
//   imem_rdata     fetched instruction
//   id_stall       decode cannot accept; current output is held
//   redirect_valid branch/jump taken; flush and refetch
//   redirect_pc    redirect target (low two bits ignored)
//   instr_valid    instr_out/pc_out hold a live instruction
//   instr_out      instruction to IF/ID
//   pc_out         PC of instr_out
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        pc_r, pc_s;
    logic               req_r, req_s;
    logic [31:0]        addr_r, addr_s;

    logic [31:0]        fifo_pc_r    [BUF_DEPTH];
    logic [31:0]        fifo_instr_r [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [PTR_W:0]     count_r, count_s;

    logic               valid_r, valid_s;
    logic [31:0]        instr_r, instr_s;
    logic [31:0]        pc_out_r, pc_out_s;

    logic               xfer_s;
    logic               push_s;
    logic               pop_s;
    logic [31:0]        redir_pc_s;

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_valid = valid_r;
    assign instr_out   = instr_r;
    assign pc_out      = pc_out_r;

    // Handshake qualifiers; a redirect discards both the push and the pop of its cycle.
    always_comb begin
        xfer_s     = req_r & imem_ready;
        push_s     = (state_r == ST_FETCH) & xfer_s & ~redirect_valid;
        pop_s      = valid_r & ~id_stall & ~redirect_valid;
        redir_pc_s = {redirect_pc[31:2], 2'b00};
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (redirect_valid) begin
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
            count_s  = {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            count_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
        end
    end

    // Next registered FIFO head; bypass the entry being written this cycle.
    always_comb begin
        valid_s  = valid_r;
        instr_s  = instr_r;
        pc_out_s = pc_out_r;
        if (redirect_valid) begin
            valid_s = 1'b0;
        end else if (count_s == {(PTR_W + 1){1'b0}}) begin
            valid_s = 1'b0;
        end else begin
            valid_s = 1'b1;
            if (push_s && (wr_ptr_r == rd_ptr_s)) begin
                instr_s  = imem_rdata;
                pc_out_s = addr_r;
            end else begin
                instr_s  = fifo_instr_r[rd_ptr_s];
                pc_out_s = fifo_pc_r[rd_ptr_s];
            end
        end
    end

    // Fetch FSM next state, PC and request register values.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        req_s   = req_r;
        addr_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                req_s   = 1'b1;
                if (redirect_valid) begin
                    pc_s   = redir_pc_s;
                    addr_s = redir_pc_s;
                end else begin
                    addr_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_s = redir_pc_s;
                    if (xfer_s) begin
                        state_s = ST_FETCH;
                        req_s   = 1'b1;
                        addr_s  = redir_pc_s;
                    end else begin
                        // Old request stays on the bus until memory takes it.
                        state_s = ST_DRAIN;
                    end
                end else if (xfer_s) begin
                    pc_s = pc_r + PC_STEP;
                    if (count_s == DEPTH_C) begin
                        state_s = ST_HOLD;
                        req_s   = 1'b0;
                    end else begin
                        state_s = ST_FETCH;
                        req_s   = 1'b1;
                        addr_s  = pc_r + PC_STEP;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_s    = redir_pc_s;
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                    addr_s  = redir_pc_s;
                end else if (count_s < DEPTH_C) begin
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_s = redir_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                if (xfer_s) begin
                    // Killed response arrives now; its data is never pushed.
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                    addr_s  = pc_s;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
                addr_s  = pc_r;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            req_r    <= 1'b0;
            addr_r   <= RESET_PC;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            valid_r  <= 1'b0;
            instr_r  <= 32'h0000_0000;
            pc_out_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            req_r    <= req_s;
            addr_r   <= addr_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
            valid_r  <= valid_s;
            instr_r  <= instr_s;
            pc_out_r <= pc_out_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= addr_r;
            fifo_instr_r[wr_ptr_r] <= imem_rdata;
        end else begin
            fifo_pc_r[wr_ptr_r]    <= fifo_pc_r[wr_ptr_r];
            fifo_instr_r[wr_ptr_r] <= fifo_instr_r[wr_ptr_r];
        end
    end

endmodule
